// File: rtl/gray_wptr_full_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gray_wptr_full_pkg                                              |
// | Brief    : Shared FIFO pointer helpers (binary <-> Gray conversion).       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package gray_wptr_full_pkg;

    // Helpers work on a wide container; callers zero-extend and truncate.
    localparam int c_PTR_MAX_W = 32;

    function automatic logic [c_PTR_MAX_W-1:0] bin2gray(input logic [c_PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down; leading zeros leave the result unaffected.
    function automatic logic [c_PTR_MAX_W-1:0] gray2bin(input logic [c_PTR_MAX_W-1:0] gray);
        logic [c_PTR_MAX_W-1:0] bin;
        bin[c_PTR_MAX_W-1] = gray[c_PTR_MAX_W-1];
        for (int i = c_PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_wptr_full.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gray_wptr_full                                                  |
// | Brief    : Async-FIFO write pointer, Gray pointer, full/level/overflow.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module gray_wptr_full
    import gray_wptr_full_pkg::*;
#(
    parameter int ASIZE        = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic             src_clk,
    input  logic             in_reset,
    input  logic             winc,
    input  logic [ASIZE:0]   rptr_sync,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow
);

    localparam int             c_PW     = ASIZE + 1;
    localparam logic [ASIZE:0] c_AFULL  = c_PW'(AFULL_THRESH);

    logic [ASIZE:0] r_wbin;
    logic [ASIZE:0] r_wptr;
    logic           r_wfull;
    logic           r_walmost_full;
    logic [ASIZE:0] r_wlevel;
    logic           r_woverflow;

    logic           w_accept;
    logic [ASIZE:0] w_wbin_next;
    logic [ASIZE:0] w_wgray_next;
    logic [ASIZE:0] w_rbin;
    logic [ASIZE:0] w_level_next;
    logic [ASIZE:0] w_full_ptr;

    assign w_accept     = winc & ~r_wfull;
    assign w_wbin_next  = r_wbin + {{ASIZE{1'b0}}, w_accept};
    assign w_wgray_next = c_PW'(bin2gray(c_PTR_MAX_W'(w_wbin_next)));
    assign w_rbin       = c_PW'(gray2bin(c_PTR_MAX_W'(rptr_sync)));
    assign w_level_next = w_wbin_next - w_rbin;
    // Full when the write pointer has lapped the read pointer by one full depth.
    assign w_full_ptr   = {~rptr_sync[ASIZE:ASIZE-1], rptr_sync[ASIZE-2:0]};

    always_ff @(posedge src_clk or posedge in_reset) begin
        if (in_reset) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wlevel       <= '0;
            r_woverflow    <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr         <= w_wgray_next;
            r_wfull        <= (w_wgray_next == w_full_ptr);
            r_walmost_full <= (w_level_next >= c_AFULL);
            r_wlevel       <= w_level_next;
            r_woverflow    <= r_woverflow | (winc & r_wfull);
        end
    end

    assign waddr        = r_wbin[ASIZE-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;
    assign woverflow    = r_woverflow;

endmodule
`default_nettype wire

// File: tb/tb_gray_wptr_full.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_gray_wptr_full                                               |
// | Brief    : Self-checking bench for gray_wptr_full (ASIZE=3, THRESH=6).     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_gray_wptr_full;

    localparam int ASIZE        = 3;
    localparam int AFULL_THRESH = 6;
    localparam int DEPTH        = 8;

    logic             src_clk = 1'b0;
    logic             in_reset;
    logic             winc;
    logic [ASIZE:0]   rptr_sync;
    logic [ASIZE-1:0] waddr;
    logic [ASIZE:0]   wptr;
    logic             wfull;
    logic             walmost_full;
    logic [ASIZE:0]   wlevel;
    logic             woverflow;

    gray_wptr_full #(.ASIZE(ASIZE), .AFULL_THRESH(AFULL_THRESH)) dut (
        .src_clk      (src_clk),
        .in_reset     (in_reset),
        .winc         (winc),
        .rptr_sync    (rptr_sync),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 src_clk = ~src_clk;

    typedef struct {
        int waddr;
        int wptr;
        int wfull;
        int wafull;
        int wlevel;
        int wovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model in unbounded write/read counts.
    int             m_wcnt;
    int             m_rd;
    bit             m_full;
    bit             m_ovf;
    bit             full_seen;
    logic [ASIZE:0] prev_wptr;

    function automatic logic [ASIZE:0] gray(input int b);
        logic [ASIZE:0] v;
        v = b[ASIZE:0];
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_waddr"},  int'(waddr),        0);
        check({tag, "_wptr"},   int'(wptr),         0);
        check({tag, "_wfull"},  int'(wfull),        0);
        check({tag, "_wafull"}, int'(walmost_full), 0);
        check({tag, "_wlevel"}, int'(wlevel),       0);
        check({tag, "_wovf"},   int'(woverflow),    0);
    endtask

    task automatic model_reset();
        m_wcnt    = 0;
        m_rd      = 0;
        m_full    = 1'b0;
        m_ovf     = 1'b0;
        prev_wptr = '0;
    endtask

    // One clock: drive at negedge, predict, then compare just after the rising edge.
    task automatic step(input logic w, input int rd);
        exp_t e;
        int   lvl;
        @(negedge src_clk);
        in_reset  = 1'b0;
        winc      = w;
        rptr_sync = gray(rd);
        if (w && m_full) m_ovf = 1'b1;
        if (w && !m_full) m_wcnt++;
        m_rd     = rd;
        lvl      = m_wcnt - m_rd;
        m_full   = (lvl == DEPTH);
        e.waddr  = m_wcnt % DEPTH;
        e.wptr   = int'(gray(m_wcnt));
        e.wfull  = int'(m_full);
        e.wafull = int'(lvl >= AFULL_THRESH);
        e.wlevel = lvl;
        e.wovf   = int'(m_ovf);
        exp_q.push_back(e);
        @(posedge src_clk);
        #1;
        e = exp_q.pop_front();
        check("waddr",  int'(waddr),        e.waddr);
        check("wptr",   int'(wptr),         e.wptr);
        check("wfull",  int'(wfull),        e.wfull);
        check("wafull", int'(walmost_full), e.wafull);
        check("wlevel", int'(wlevel),       e.wlevel);
        check("wovf",   int'(woverflow),    e.wovf);
        check("gray_1bit", int'($countones(wptr ^ prev_wptr) <= 1), 1);
        if (wfull) full_seen = 1'b1;
        prev_wptr = wptr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hist[$];

        // Reset held with a write request: everything stays at zero.
        in_reset  = 1'b1;
        winc      = 1'b1;
        rptr_sync = '0;
        #1;
        check_all_zero("rst_async");
        repeat (3) @(posedge src_clk);
        #1;
        check_all_zero("rst_clocked");
        model_reset();

        // First write right after release.
        step(1'b1, 0);
        check("first_waddr", int'(waddr), 1);
        check("first_wptr",  int'(wptr),  4'b0001);

        // Fill to eight entries with the read pointer parked at zero.
        for (int i = 2; i <= 8; i++) begin
            step(1'b1, 0);
            if (i == 5) check("afull_before_6", int'(walmost_full), 0);
            if (i == 6) check("afull_at_6",     int'(walmost_full), 1);
        end
        check("fill_wfull",  int'(wfull),  1);
        check("fill_wptr",   int'(wptr),   4'b1100);
        check("fill_wlevel", int'(wlevel), 8);

        // Writes while full are dropped and flagged.
        step(1'b1, 0);
        step(1'b1, 0);
        check("ovf_waddr", int'(waddr),     0);
        check("ovf_wptr",  int'(wptr),      4'b1100);
        check("ovf_flag",  int'(woverflow), 1);
        step(1'b0, 0);
        check("ovf_sticky", int'(woverflow), 1);

        // One read frees a slot; the held write refills it.
        step(1'b1, 1);
        check("drain_wfull",  int'(wfull),  0);
        check("drain_wlevel", int'(wlevel), 7);
        step(1'b1, 1);
        check("refill_wfull", int'(wfull), 1);

        // Empty out, write five, then pulse reset without a clock edge.
        step(1'b0, 9);
        for (int i = 0; i < 5; i++) step(1'b1, 9);
        check("pre_rst_wlevel", int'(wlevel), 5);
        #2;
        in_reset = 1'b1;
        #1;
        check("midrst_wlevel", int'(wlevel),    0);
        check("midrst_wptr",   int'(wptr),      0);
        check("midrst_wovf",   int'(woverflow), 0);
        check("midrst_wfull",  int'(wfull),     0);
        model_reset();

        // Sixteen writes with the read pointer trailing two cycles behind.
        full_seen = 1'b0;
        hist      = '{0, 0};
        for (int i = 0; i < 16; i++) begin
            step(1'b1, hist[hist.size() - 2]);
            hist.push_back(m_wcnt);
        end
        check("wrap_wptr",      int'(wptr),      4'b0000);
        check("wrap_full_seen", int'(full_seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_wptr_full.md
GRAY_WPTR_FULL -- requirements
Module: gray_wptr_full

Interface
REQ-001 SHALL have parameter ASIZE, default 3, meaning the FIFO address width; depth = 2^ASIZE, and legal values are ASIZE >= 2.
REQ-002 SHALL have parameter AFULL_THRESH, default 6, meaning the occupancy at or above which walmost_full asserts; legal range is 1..2^ASIZE.
REQ-003 SHALL have port src_clk, input, 1 bit: the single clock (write domain); all logic is clocked on its rising edge.
REQ-004 SHALL have port in_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port winc, input, 1 bit: write request.
REQ-006 SHALL have port rptr_sync, input, ASIZE+1 bits: Gray-coded read pointer, already synchronized into src_clk.
REQ-007 SHALL have port waddr, output, ASIZE bits: binary write address to the FIFO memory.
REQ-008 SHALL have port wptr, output, ASIZE+1 bits: registered Gray-coded write pointer, sent to the read-domain synchronizer.
REQ-009 SHALL have port wfull, output, 1 bit: FIFO full.
REQ-010 SHALL have port walmost_full, output, 1 bit: occupancy >= AFULL_THRESH.
REQ-011 SHALL have port wlevel, output, ASIZE+1 bits: conservative write-side occupancy, range 0..2^ASIZE.
REQ-012 SHALL have port woverflow, output, 1 bit: sticky error flag for a write attempted while full.

Function
REQ-013 SHALL hold an internal binary pointer wbin of ASIZE+1 bits; waddr = wbin[ASIZE-1:0].
REQ-014 SHALL accept a write in a cycle iff winc=1 and wfull=0, using the registered wfull.
REQ-015 SHALL compute wbin_next = wbin + accept, modulo 2^(ASIZE+1), so the pointer wraps silently.
REQ-016 SHALL compute wgray_next = (wbin_next >> 1) XOR wbin_next and register it into wptr on the same edge as wbin; wptr therefore changes one cycle after the accepted write.
REQ-017 SHALL guarantee that wptr changes by at most one bit per src_clk cycle.
REQ-018 SHALL register wfull <= (wgray_next == {~rptr_sync[ASIZE:ASIZE-1], rptr_sync[ASIZE-2:0]}), so wfull asserts in the cycle after the write that fills the FIFO.
REQ-019 SHALL deassert wfull one cycle after an rptr_sync change frees space; there is no combinational path from rptr_sync to any output.
REQ-020 SHALL convert rptr_sync to binary rbin by prefix-XOR from the MSB.
REQ-021 SHALL register wlevel <= wbin_next - rbin, modulo 2^(ASIZE+1).
REQ-022 SHALL register walmost_full <= ((wbin_next - rbin) >= AFULL_THRESH).
REQ-023 SHALL set woverflow to 1 on any cycle with winc=1 and wfull=1, and hold it until reset.
REQ-024 SHALL, on a rejected write, leave wbin, waddr, wptr and wlevel unchanged.
REQ-025 SHALL handle a simultaneous write accept and rptr_sync change in one cycle by using both in the same next-state computation; no event priority applies.
REQ-026 SHALL treat wfull, walmost_full and wlevel as pessimistic, since rptr_sync lags by the synchronizer delay; they never under-report occupancy.

Reset
REQ-027 SHALL, while in_reset=1, asynchronously force wbin=0, wptr=0, waddr=0, wfull=0, walmost_full=0, wlevel=0 and woverflow=0.
REQ-028 SHALL, when reset is asserted mid-operation, discard all pointer state immediately; the first write is accepted on the first rising edge after in_reset deasserts.

Structure
REQ-029 SHALL place the bin2gray and gray2bin functions, parameterized by width, in the shared FIFO package/include; the read-side pointer block reuses them.
REQ-030 SHALL be implemented as a single module with no sub-modules; the read-pointer synchronizer is instantiated by the parent, not inside this block.
REQ-031 SHALL use only src_clk for sequential elements and SHALL contain no synchronizer flops.

Verification (ASIZE=3, AFULL_THRESH=6)
REQ-032 SHALL cover reset: assert in_reset with winc=1 -> all outputs 0; after release, the first winc gives waddr=1 and wptr=4'b0001 on the next cycle.
REQ-033 SHALL cover fill: rptr_sync=0, 8 consecutive winc -> walmost_full=1 after the 6th write; wfull=1, wptr=4'b1100 and wlevel=8 after the 8th.
REQ-034 SHALL cover overflow: winc=1 while full -> waddr stays 0, wptr stays 4'b1100, woverflow=1 and remains 1 after winc drops.
REQ-035 SHALL cover drain: from full, rptr_sync=4'b0001 -> wfull=0 and wlevel=7 one cycle later; with winc held, wfull=1 again one cycle after the next accepted write.
REQ-036 SHALL cover wrap: 16 writes with rptr_sync tracking wptr two cycles late -> wptr returns to 4'b0000, wfull never asserts, and the bench checks one-bit Gray transitions on every cycle.
REQ-037 SHALL cover reset mid-operation: in_reset pulsed after 5 writes -> wlevel=0, wptr=0 and woverflow=0 immediately, with no wait for a clock edge.
